// File: rtl/dma_ch_sched.sv
`timescale 1ns/1ps
// dma_ch_sched
//   Multi-channel descriptor scheduler. Each channel owns a small descriptor
//   FIFO ({src,dst,num_bytes}). A round-robin arbiter selects one eligible
//   channel at a time. Its descriptor goes to the DMA streamer, and the block
//   then waits for the streamer's completion pulse. It reports per-channel done
//   pulses, sticky per-channel errors and the last captured error
//   address/source/channel.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     desc_valid_i/ready  per-channel descriptor push handshake
//     desc_i              packed {src,dst,num} per channel, ch0 at LSB
//     ch_prio_i           per-channel high-priority flag (DMA_PRIO_EN only)
//     ch_clr_i            clear sticky error and flush the channel's queue
//     str_*               descriptor issue / completion interface to streamer
//     ch_done_o           1-cycle pulse per successfully completed descriptor
//     ch_err_o            sticky per-channel error
//     err_valid_o/err_*   error capture pulse and held error information
//     busy_o              transfer in progress or any queue non-empty
//
//   Build option: define DMA_PRIO_EN to add a high-priority class. Eligible
//   channels with ch_prio_i=1 then win over all other channels, and each class
//   keeps its own round-robin pointer.
module dma_ch_sched #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned Q_DEPTH = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BYTES_W = 32,
    localparam int unsigned DW     = 2*ADDR_W + BYTES_W,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    desc_valid_i,
    output logic [NUM_CH-1:0]    desc_ready_o,
    input  logic [NUM_CH*DW-1:0] desc_i,
    input  logic [NUM_CH-1:0]    ch_prio_i,
    input  logic [NUM_CH-1:0]    ch_clr_i,
    output logic                 str_valid_o,
    input  logic                 str_ready_i,
    output logic [DW-1:0]        str_desc_o,
    output logic [CH_W-1:0]      str_ch_o,
    input  logic                 str_done_i,
    input  logic                 str_err_i,
    input  logic [ADDR_W-1:0]    str_err_addr_i,
    input  logic [1:0]           str_err_src_i,
    output logic [NUM_CH-1:0]    ch_done_o,
    output logic [NUM_CH-1:0]    ch_err_o,
    output logic                 err_valid_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic [1:0]           err_src_o,
    output logic [CH_W-1:0]      err_ch_o,
    output logic                 busy_o
);

    localparam int unsigned QA    = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = QA + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    state_t state;

    logic [DW-1:0]     q_mem [NUM_CH][Q_DEPTH];
    logic [QA-1:0]     q_rd  [NUM_CH];
    logic [QA-1:0]     q_wr  [NUM_CH];
    logic [CNT_W-1:0]  q_cnt [NUM_CH];
    logic [NUM_CH-1:0] q_full, q_nempty, push, pop, elig;
    logic [CH_W-1:0]   grant;
    logic [DW-1:0]     head;

    // Round-robin search starting at 'start', wrapping NUM_CH-1 -> 0.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   start);
        logic [CH_W-1:0] sel;
        logic            found;
        int unsigned     idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(start) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[CH_W-1:0];
            end
        end
        return sel;
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            q_full[c]   = (q_cnt[c] == CNT_W'(Q_DEPTH));
            q_nempty[c] = (q_cnt[c] != '0);
            q_wr[c]     = q_rd[c] + q_cnt[c][QA-1:0];
        end
    end

    // Ready comes from registered occupancy only, so a pop in the same cycle
    // does not free space for a push.
    assign desc_ready_o = ~q_full & ~ch_clr_i;
    assign push         = desc_valid_i & desc_ready_o;
    assign elig         = q_nempty & ~ch_err_o;

`ifdef DMA_PRIO_EN
    logic [CH_W-1:0]   rr_hi, rr_lo;
    logic [NUM_CH-1:0] elig_hi;
    logic              use_hi;
    assign elig_hi = elig & ch_prio_i;
    assign use_hi  = |elig_hi;
    assign grant   = use_hi ? rr_pick(elig_hi, rr_hi) : rr_pick(elig, rr_lo);
`else
    logic [CH_W-1:0] rr_ptr;
    logic            prio_unused;
    assign prio_unused = ^ch_prio_i;
    assign grant       = rr_pick(elig, rr_ptr);
`endif

    assign head = q_mem[grant][q_rd[grant]];

    always_comb begin
        pop = '0;
        if (state == ST_IDLE && |elig) pop[grant] = 1'b1;
    end

    assign busy_o = (state != ST_IDLE) | (|q_nempty);

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push[c]) q_mem[c][q_wr[c]] <= desc_i[c*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                q_cnt[c] <= '0;
                q_rd[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_clr_i[c]) begin
                    q_cnt[c] <= '0;
                    q_rd[c]  <= '0;
                end else begin
                    if (pop[c]) q_rd[c] <= q_rd[c] + 1'b1;
                    case ({push[c], pop[c]})
                        2'b10:   q_cnt[c] <= q_cnt[c] + 1'b1;
                        2'b01:   q_cnt[c] <= q_cnt[c] - 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            str_valid_o <= 1'b0;
            str_desc_o  <= '0;
            str_ch_o    <= '0;
            ch_done_o   <= '0;
            ch_err_o    <= '0;
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_src_o   <= '0;
            err_ch_o    <= '0;
`ifdef DMA_PRIO_EN
            rr_hi       <= '0;
            rr_lo       <= '0;
`else
            rr_ptr      <= '0;
`endif
        end else begin
            ch_done_o   <= '0;
            err_valid_o <= 1'b0;
            // An error reported in the same cycle as a clear wins (assigned below).
            ch_err_o    <= ch_err_o & ~ch_clr_i;
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
`ifdef DMA_PRIO_EN
                        if (use_hi) rr_hi <= next_ch(grant);
                        else        rr_lo <= next_ch(grant);
`else
                        rr_ptr <= next_ch(grant);
`endif
                        // Zero-byte descriptors complete without a streamer round trip.
                        if (head[BYTES_W-1:0] == '0) begin
                            ch_done_o[grant] <= 1'b1;
                        end else begin
                            str_valid_o <= 1'b1;
                            str_desc_o  <= head;
                            str_ch_o    <= grant;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (str_ready_i) begin
                        str_valid_o <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // str_ch_o still holds the in-flight channel here.
                    if (str_done_i) begin
                        if (str_err_i) begin
                            ch_err_o[str_ch_o] <= 1'b1;
                            err_valid_o        <= 1'b1;
                            err_addr_o         <= str_err_addr_i;
                            err_src_o          <= str_err_src_i;
                            err_ch_o           <= str_ch_o;
                        end else begin
                            ch_done_o[str_ch_o] <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ch_sched.sv
`timescale 1ns/1ps
module tb_dma_ch_sched;

    localparam int NUM_CH  = 4;
    localparam int Q_DEPTH = 2;
    localparam int ADDR_W  = 32;
    localparam int BYTES_W = 32;
    localparam int DW      = 2*ADDR_W + BYTES_W;
    localparam int CH_W    = 2;

    logic                 clk, rst_n;
    logic [NUM_CH-1:0]    v, prio, clr;
    logic [NUM_CH*DW-1:0] d_i;
    logic                 sr, sd, se;
    logic [ADDR_W-1:0]    sa;
    logic [1:0]           ss;

    logic [NUM_CH-1:0]    desc_ready_o, ch_done_o, ch_err_o;
    logic                 str_valid_o, err_valid_o, busy_o;
    logic [DW-1:0]        str_desc_o;
    logic [CH_W-1:0]      str_ch_o, err_ch_o;
    logic [ADDR_W-1:0]    err_addr_o;
    logic [1:0]           err_src_o;

    dma_ch_sched #(.NUM_CH(NUM_CH), .Q_DEPTH(Q_DEPTH), .ADDR_W(ADDR_W), .BYTES_W(BYTES_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid_i(v), .desc_ready_o(desc_ready_o), .desc_i(d_i),
        .ch_prio_i(prio), .ch_clr_i(clr),
        .str_valid_o(str_valid_o), .str_ready_i(sr), .str_desc_o(str_desc_o), .str_ch_o(str_ch_o),
        .str_done_i(sd), .str_err_i(se), .str_err_addr_i(sa), .str_err_src_i(ss),
        .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_src_o(err_src_o), .err_ch_o(err_ch_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0]     mq [NUM_CH][$];
    int                m_stage;   // 0 none in flight, 1 offered, 2 accepted by streamer
    logic [DW-1:0]     m_cur;
    int                m_ch, m_rr, m_rr_hi, m_ech;
    logic [NUM_CH-1:0] m_err, m_done;
    logic              m_errv;
    logic [ADDR_W-1:0] m_eaddr;
    logic [1:0]        m_esrc;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_stage = 0; m_cur = '0; m_ch = 0; m_rr = 0; m_rr_hi = 0; m_ech = 0;
        m_err = '0; m_done = '0; m_errv = 1'b0; m_eaddr = '0; m_esrc = '0;
    endtask

    function automatic logic [NUM_CH-1:0] m_ready();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (mq[c].size() < Q_DEPTH) && !clr[c];
        return r;
    endfunction

    function automatic int pick(input logic [NUM_CH-1:0] m, input int start);
        for (int i = 0; i < NUM_CH; i++) if (m[(start + i) % NUM_CH]) return (start + i) % NUM_CH;
        return -1;
    endfunction

    task automatic model_step();
        logic [NUM_CH-1:0] rdy, el;
        logic [DW-1:0]     d;
        int                g;
        bit                set_err;
        rdy = m_ready();
        for (int c = 0; c < NUM_CH; c++) el[c] = (mq[c].size() != 0) && !m_err[c];
        m_done = '0; m_errv = 1'b0; set_err = 0; g = -1;
        if (m_stage == 0) begin
`ifdef DMA_PRIO_EN
            if ((el & prio) != '0) begin g = pick(el & prio, m_rr_hi); m_rr_hi = (g + 1) % NUM_CH; end
            else if (el != '0)     begin g = pick(el, m_rr);           m_rr    = (g + 1) % NUM_CH; end
`else
            if (el != '0) begin g = pick(el, m_rr); m_rr = (g + 1) % NUM_CH; end
`endif
            if (g >= 0) begin
                d = mq[g].pop_front();
                if (d[BYTES_W-1:0] == '0) m_done[g] = 1'b1;
                else begin m_stage = 1; m_cur = d; m_ch = g; end
            end
        end else if (m_stage == 1) begin
            if (sr) m_stage = 2;
        end else if (sd) begin
            if (se) set_err = 1; else m_done[m_ch] = 1'b1;
            m_stage = 0;
        end
        for (int c = 0; c < NUM_CH; c++) if (clr[c]) begin m_err[c] = 1'b0; mq[c].delete(); end
        if (set_err) begin
            m_err[m_ch] = 1'b1; m_errv = 1'b1; m_eaddr = sa; m_esrc = ss; m_ech = m_ch;
        end
        for (int c = 0; c < NUM_CH; c++) if (v[c] && rdy[c]) mq[c].push_back(d_i[c*DW +: DW]);
    endtask

    task automatic check_outputs();
        bit any_q = 0;
        for (int c = 0; c < NUM_CH; c++) if (mq[c].size() != 0) any_q = 1;
        chk("str_valid", str_valid_o, m_stage == 1);
        if (m_stage == 1) begin
            chk("str_ch", str_ch_o, m_ch);
            chk("str_desc", str_desc_o, m_cur);
        end
        chk("ch_done", ch_done_o, m_done);
        chk("ch_err", ch_err_o, m_err);
        chk("err_valid", err_valid_o, m_errv);
        chk("err_addr", err_addr_o, m_eaddr);
        chk("err_src", err_src_o, m_esrc);
        chk("err_ch", err_ch_o, m_ech);
        chk("busy", busy_o, (m_stage != 0) || any_q);
    endtask

    // One clock: called at posedge+1 after inputs are set.
    task automatic cyc();
        #1;
        chk("desc_ready", desc_ready_o, m_ready());
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic put(input int c, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t,
                       input logic [BYTES_W-1:0] n);
        v[c] = 1'b1;
        d_i[c*DW +: DW] = {s, t, n};
    endtask

    task automatic idle_inputs();
        v = '0; clr = '0; sr = 1'b0; sd = 1'b0; se = 1'b0; sa = '0; ss = '0;
    endtask

    task automatic drain(input int n);
        sr = 1'b1; sd = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        sr = 1'b0; sd = 1'b0;
        chk("drained_busy", busy_o, 1'b0);
    endtask

    int order[$];

    // Streamer accepts at once and signals done 3 cycles after acceptance.
    task automatic collect_grants(input int want);
        int tmr = 0;
        order.delete();
        sr = 1'b1;
        for (int n = 0; n < 300 && !(order.size() == want && !busy_o); n++) begin
            sd = 1'b0;
            if (tmr > 0) begin tmr--; if (tmr == 0) sd = 1'b1; end
            if (str_valid_o) begin order.push_back(int'(str_ch_o)); tmr = 3; end
            cyc();
        end
        sr = 1'b0; sd = 1'b0;
        chk("grant_count", order.size(), want);
    endtask

    task automatic reset_checks();
        chk("rst_ready", desc_ready_o, 4'hF);
        chk("rst_valid", str_valid_o, 1'b0);
        chk("rst_done", ch_done_o, 4'h0);
        chk("rst_err", ch_err_o, 4'h0);
        chk("rst_errv", err_valid_o, 1'b0);
        chk("rst_eaddr", err_addr_o, 32'h0);
        chk("rst_esrc", err_src_o, 2'h0);
        chk("rst_ech", err_ch_o, 2'h0);
        chk("rst_busy", busy_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; prio = '0; d_i = '0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;

        // Single descriptor on ch2: valid 2 cycles after handshake.
        put(2, 32'h1000, 32'h2000, 32'd64);
        cyc();
        v = '0;
        chk("t1_not_yet", str_valid_o, 1'b0);
        cyc();
        chk("t1_valid", str_valid_o, 1'b1);
        chk("t1_ch", str_ch_o, 2'd2);
        chk("t1_desc", str_desc_o, {32'h1000, 32'h2000, 32'd64});
        sr = 1'b1; cyc(); sr = 1'b0;
        sd = 1'b1; cyc(); sd = 1'b0;
        chk("t1_done", ch_done_o, 4'b0100);
        cyc();
        chk("t1_done_pulse", ch_done_o, 4'b0000);

        // Fill ch0 while the streamer stalls.
        put(0, 32'hA0, 32'hB0, 32'd8); cyc();
        put(0, 32'hA1, 32'hB1, 32'd8); cyc();
        put(0, 32'hA2, 32'hB2, 32'd8); cyc();
        put(0, 32'hA3, 32'hB3, 32'd8);
        #1 chk("t2_full", desc_ready_o[0], 1'b0);
        cyc();
        v = '0;
        sr = 1'b1; cyc(); sr = 1'b0;
        sd = 1'b1; cyc(); sd = 1'b0;
        chk("t2_still_full", desc_ready_o[0], 1'b0);
        cyc();
        chk("t2_ready_back", desc_ready_o[0], 1'b1);
        drain(12);

        // Zero-byte descriptor on ch3: no streamer activity, done pulse.
        put(3, 32'h0, 32'h0, 32'd0); cyc(); v = '0;
        cyc();
        chk("t5_no_valid", str_valid_o, 1'b0);
        chk("t5_done", ch_done_o, 4'b1000);
        cyc();

        // Every queue two deep: strict round robin.
        for (int c = 0; c < NUM_CH; c++) put(c, 32'(c), 32'(c + 16), 32'd32);
        cyc();
        for (int c = 0; c < NUM_CH; c++) put(c, 32'(c + 32), 32'(c + 48), 32'd32);
        cyc();
        v = '0;
        collect_grants(8);
        for (int i = 0; i < 8 && i < order.size(); i++) chk("rr_order", order[i], i % 4);

        // Error on ch1, then ch1 masked, then cleared.
        put(1, 32'h100, 32'h200, 32'd16); cyc(); v = '0;
        cyc();
        sr = 1'b1; cyc(); sr = 1'b0;
        sd = 1'b1; se = 1'b1; sa = 32'h3FFC; ss = 2'd2; cyc();
        sd = 1'b0; se = 1'b0; sa = '0; ss = '0;
        chk("t4_errv", err_valid_o, 1'b1);
        chk("t4_err", ch_err_o, 4'b0010);
        chk("t4_eaddr", err_addr_o, 32'h3FFC);
        chk("t4_esrc", err_src_o, 2'd2);
        chk("t4_ech", err_ch_o, 2'd1);
        put(1, 32'h300, 32'h400, 32'd4);
        put(2, 32'h500, 32'h600, 32'd4);
        cyc(); v = '0;
        chk("t4_errv_pulse", err_valid_o, 1'b0);
        cyc();
        chk("t4_skip_ch", str_ch_o, 2'd2);
        sr = 1'b1; cyc(); sr = 1'b0;
        sd = 1'b1; cyc(); sd = 1'b0;
        cyc(); cyc();
        chk("t4_masked_valid", str_valid_o, 1'b0);
        chk("t4_masked_busy", busy_o, 1'b1);
        clr = 4'b0010;
        #1 chk("t4_clr_ready", desc_ready_o[1], 1'b0);
        cyc(); clr = '0;
        chk("t4_cleared", ch_err_o, 4'b0000);
        chk("t4_flushed", busy_o, 1'b0);
        chk("t4_held_addr", err_addr_o, 32'h3FFC);

        // Reset asserted while waiting on the streamer.
        put(0, 32'h700, 32'h800, 32'd4);
        put(2, 32'h900, 32'hA00, 32'd4);
        cyc(); v = '0;
        cyc();
        sr = 1'b1; cyc(); sr = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_checks();
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef DMA_PRIO_EN
        prio = 4'b1000;
        for (int c = 0; c < NUM_CH; c++) put(c, 32'(c), 32'(c), 32'd8);
        cyc();
        for (int c = 0; c < NUM_CH; c++) put(c, 32'(c + 8), 32'(c + 8), 32'd8);
        cyc();
        v = '0;
        collect_grants(8);
        begin
            int exp_ord[8] = '{3, 3, 0, 1, 2, 0, 1, 2};
            for (int i = 0; i < 8 && i < order.size(); i++) chk("prio_order", order[i], exp_ord[i]);
        end
        prio = '0;
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                v[c]   = ($urandom_range(0, 9) < 4);
                clr[c] = ($urandom_range(0, 99) < 3);
                d_i[c*DW +: DW] = {$urandom(), $urandom(),
                                   ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096))};
            end
            prio = 4'($urandom());
            sr = ($urandom_range(0, 2) != 0);
            sd = ($urandom_range(0, 3) == 0);
            se = ($urandom_range(0, 3) == 0);
            sa = $urandom();
            ss = 2'($urandom());
            cyc();
        end
        idle_inputs();
        clr = 4'hF; cyc(); clr = '0;
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
